// File: rtl/inter_ram_writer_ble_pkg.sv
// Shared types and defaults for the BLE intermediate RAM writer.
// Holds the writer state encoding, default sizes and the reader wait constant.
package ble_inter_ram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } wr_state_t;

  localparam int DEF_DATA    = 12;
  localparam int DEF_MEM     = 8192;
  localparam int DEF_LENW    = 12;
  localparam int READER_WAIT = 17;

endpackage

// File: rtl/inter_ram_writer_ble_seg_counter.sv
// Segment sample counter with last-sample detect for the RAM writer.
// Ports: clk, reset, clear, inc, len -> last (cnt == len-1).
module inter_ram_wr_seg_counter #(
  parameter int LENW = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc,
  input  logic [LENW-1:0] len,
  output logic            last
);

  logic [LENW-1:0] seg_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_cnt <= '0;
    end else if (clear) begin
      seg_cnt <= '0;
    end else if (inc) begin
      seg_cnt <= seg_cnt + 1'b1;
    end
  end

  assign last = (seg_cnt == len - 1'b1);

endmodule

// File: rtl/inter_ram_writer_ble.sv
// BLE intermediate RAM writer: frames a header+payload stream into RAM writes.
// Ports: start/abort/lengths, in_* stream, tx_valid_out/wr_data RAM port,
// tx_finished, busy, len_error, aborted; INTER_RAM_WR_STATS_EN adds frame counters.
module inter_ram_writer_ble
  import ble_inter_ram_pkg::*;
#(
  parameter int DATA = DEF_DATA,
  parameter int MEM  = DEF_MEM,
  parameter int LENW = DEF_LENW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [LENW-1:0] header_len,
  input  logic [LENW-1:0] payload_len,
  input  logic            in_valid,
  input  logic [DATA-1:0] in_data,
  output logic            in_ready,
  output logic            tx_valid_out,
  output logic [DATA-1:0] wr_data,
  output logic            tx_finished,
  output logic            busy,
  output logic            len_error,
  output logic            aborted
`ifdef INTER_RAM_WR_STATS_EN
  ,
  output logic [15:0]     frames_done,
  output logic [15:0]     frames_aborted,
  output logic [15:0]     frames_rejected
`endif
);

  wr_state_t       state;
  logic [LENW-1:0] hdr_len_q;
  logic [LENW-1:0] pay_len_q;
  logic [LENW-1:0] seg_len;
  logic [LENW:0]   len_sum;
  logic            len_bad;
  logic            xfer;
  logic            seg_last;
  logic            start_ok;
  logic            hdr_to_pay;
  logic            seg_clear;

  assign in_ready = (state == HEADER) || (state == PAYLOAD);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid && in_ready;

  // Extra bit so the sum of two max lengths cannot wrap.
  assign len_sum = {1'b0, header_len} + {1'b0, payload_len};
  assign len_bad = 32'(len_sum) > 32'(MEM);

  assign start_ok   = (state == IDLE) && start && !len_bad;
  assign hdr_to_pay = (state == HEADER) && xfer && seg_last &&
                      !abort && (pay_len_q != '0);
  assign seg_clear  = start_ok || hdr_to_pay;
  assign seg_len    = (state == PAYLOAD) ? pay_len_q : hdr_len_q;

  inter_ram_wr_seg_counter #(
    .LENW(LENW)
  ) u_seg_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(seg_clear),
    .inc  (xfer),
    .len  (seg_len),
    .last (seg_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hdr_len_q    <= '0;
      pay_len_q    <= '0;
      tx_valid_out <= 1'b0;
      wr_data      <= '0;
      tx_finished  <= 1'b0;
      len_error    <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      tx_valid_out <= 1'b0;
      tx_finished  <= 1'b0;
      len_error    <= 1'b0;
      aborted      <= 1'b0;
      // A sample taken in the abort cycle is dropped.
      if (xfer && !abort) begin
        tx_valid_out <= 1'b1;
        wr_data      <= in_data;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len_bad) begin
              len_error <= 1'b1;
            end else begin
              hdr_len_q <= header_len;
              pay_len_q <= payload_len;
              if (header_len != '0)       state <= HEADER;
              else if (payload_len != '0) state <= PAYLOAD;
              else                        state <= DONE;
            end
          end
        end
        HEADER: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (xfer && seg_last) begin
            state <= (pay_len_q != '0) ? PAYLOAD : DONE;
          end
        end
        PAYLOAD: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (xfer && seg_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Finish lands after the last write has reached the RAM.
          tx_finished <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTER_RAM_WR_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_done     <= '0;
      frames_aborted  <= '0;
      frames_rejected <= '0;
    end else begin
      if (tx_finished && frames_done != 16'hFFFF)
        frames_done <= frames_done + 16'd1;
      if (aborted && frames_aborted != 16'hFFFF)
        frames_aborted <= frames_aborted + 16'd1;
      if (len_error && frames_rejected != 16'hFFFF)
        frames_rejected <= frames_rejected + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inter_ram_writer_ble.sv
// Self-checking bench for inter_ram_writer_ble.
// Random stimulus against a transfer-level frame model.
module tb_inter_ram_writer_ble;
  import ble_inter_ram_pkg::*;

  localparam int DW = 12;
  localparam int LW = 14;

  logic          clk = 0;
  logic          reset = 1;
  logic          start = 0;
  logic          abort = 0;
  logic [LW-1:0] header_len = '0;
  logic [LW-1:0] payload_len = '0;
  logic          in_valid = 0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          tx_valid_out;
  logic [DW-1:0] wr_data;
  logic          tx_finished;
  logic          busy;
  logic          len_error;
  logic          aborted;
`ifdef INTER_RAM_WR_STATS_EN
  logic [15:0]   frames_done;
  logic [15:0]   frames_aborted;
  logic [15:0]   frames_rejected;
`endif

  inter_ram_writer_ble #(
    .DATA(DW), .MEM(8192), .LENW(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .header_len(header_len), .payload_len(payload_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_valid_out(tx_valid_out), .wr_data(wr_data),
    .tx_finished(tx_finished), .busy(busy),
    .len_error(len_error), .aborted(aborted)
`ifdef INTER_RAM_WR_STATS_EN
    ,
    .frames_done(frames_done),
    .frames_aborted(frames_aborted),
    .frames_rejected(frames_rejected)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int      cyc = 0;
  logic [DW-1:0] wq[$];
  int      wcyc[$];
  logic [DW-1:0] exp_q[$];
  int      fin_cnt, fin_cyc, lerr_cnt, ab_cnt;
  logic    busy_after;
  int      rdy_bad, timeout, start_cyc;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_valid_out) begin
      wq.push_back(wr_data);
      wcyc.push_back(cyc);
    end
    if (tx_finished) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    if (len_error) lerr_cnt++;
    if (aborted) ab_cnt++;
    if (cyc == fin_cyc + 1) busy_after = busy;
  end

  task automatic clr_mon();
    wq.delete();
    wcyc.delete();
    exp_q.delete();
    fin_cnt = 0; fin_cyc = -10;
    lerr_cnt = 0; ab_cnt = 0;
    busy_after = 1'bx;
    rdy_bad = 0; timeout = 0;
  endtask

  // Model: after an accepted start the writer takes exactly h+p
  // transfers; every valid cycle in that window is one transfer.
  task automatic run_frame(input int h, input int p,
                           input bit rnd, input int abort_at);
    int rem = h + p;
    int idx = 0;
    int guard = 0;
    @(negedge clk);
    start = 1;
    header_len = LW'(h);
    payload_len = LW'(p);
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 0;
    while (rem > 0) begin
      if (guard++ > 40000) begin
        timeout = 1;
        break;
      end
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = DW'($urandom);
      if (in_ready !== 1'b1) rdy_bad++;
      if (in_valid) begin
        if (idx == abort_at) begin
          abort = 1;
          rem = 0;
        end else begin
          exp_q.push_back(in_data);
          rem--;
        end
        idx++;
      end
      @(negedge clk);
      abort = 0;
    end
    in_valid = 0;
    if (in_ready !== 1'b0) rdy_bad++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, tx_valid_out, tx_finished, busy, len_error, aborted} !== 6'b0
        || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b fin=%b busy=%b le=%b ab=%b wd=%h want all 0",
               in_ready, tx_valid_out, tx_finished, busy, len_error, aborted, wr_data);
    end
  endtask

  task automatic test_basic();
    clr_mon();
    run_frame(4, 6, 0, -1);
    checks++;
    if (timeout != 0 || rdy_bad != 0) begin
      errors++;
      $display("FAIL basic_ready: rdy_bad=%0d timeout=%0d want 0", rdy_bad, timeout);
    end
    checks++;
    if (wq.size() != 10) begin
      errors++;
      $display("FAIL basic_count: got %0d writes want 10", wq.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wq[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_data[%0d]: got %h want %h", i, wq[i], exp_q[i]);
        end
      end
      checks++;
      if (fin_cnt != 1 || fin_cyc != wcyc[9] + 1) begin
        errors++;
        $display("FAIL basic_finish: cnt=%0d cyc=%0d want 1 at %0d",
                 fin_cnt, fin_cyc, wcyc[9] + 1);
      end
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_after: got %b want 0", busy_after);
    end
  endtask

  task automatic test_short_frames();
    clr_mon();
    run_frame(0, 3, 0, -1);
    checks++;
    if (wq.size() != 3 || fin_cnt != 1 || rdy_bad != 0) begin
      errors++;
      $display("FAIL no_header: writes=%0d fin=%0d rdy_bad=%0d want 3 1 0",
               wq.size(), fin_cnt, rdy_bad);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL no_header_data[%0d]: want %h", i, exp_q[i]);
      end
    end
    clr_mon();
    run_frame(0, 0, 0, -1);
    checks++;
    if (wq.size() != 0 || fin_cnt != 1 || fin_cyc != start_cyc + 1) begin
      errors++;
      $display("FAIL empty_frame: writes=%0d fin=%0d at %0d want 0 1 at %0d",
               wq.size(), fin_cnt, fin_cyc, start_cyc + 1);
    end
  endtask

  task automatic test_len_check();
    clr_mon();
    @(negedge clk);
    start = 1;
    header_len = LW'(4000);
    payload_len = LW'(4193);
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL len_reject_idle: busy=%b rdy=%b want 0 0", busy, in_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (lerr_cnt != 1 || wq.size() != 0 || fin_cnt != 0) begin
      errors++;
      $display("FAIL len_reject: le=%0d writes=%0d fin=%0d want 1 0 0",
               lerr_cnt, wq.size(), fin_cnt);
    end
    clr_mon();
    run_frame(4096, 4096, 0, -1);
    checks++;
    if (lerr_cnt != 0 || wq.size() != 8192 || fin_cnt != 1 || timeout != 0) begin
      errors++;
      $display("FAIL len_exact_mem: le=%0d writes=%0d fin=%0d want 0 8192 1",
               lerr_cnt, wq.size(), fin_cnt);
    end
  endtask

  task automatic test_gaps();
    clr_mon();
    run_frame(5, 5, 1, -1);
    checks++;
    if (wq.size() != 10 || fin_cnt != 1 || rdy_bad != 0 || timeout != 0) begin
      errors++;
      $display("FAIL gaps_count: writes=%0d fin=%0d rdy_bad=%0d want 10 1 0",
               wq.size(), fin_cnt, rdy_bad);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gaps_data[%0d]: want %h", i, exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    clr_mon();
    run_frame(3, 4, 1, 3 + 2);
    checks++;
    if (ab_cnt != 1 || fin_cnt != 0 || wq.size() != 5 || rdy_bad != 0) begin
      errors++;
      $display("FAIL abort: ab=%0d fin=%0d writes=%0d rdy_bad=%0d want 1 0 5 0",
               ab_cnt, fin_cnt, wq.size(), rdy_bad);
    end
    clr_mon();
    run_frame(2, 3, 0, -1);
    checks++;
    if (ab_cnt != 0 || fin_cnt != 1 || wq.size() != 5 || rdy_bad != 0) begin
      errors++;
      $display("FAIL abort_recover: ab=%0d fin=%0d writes=%0d want 0 1 5",
               ab_cnt, fin_cnt, wq.size());
    end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    @(negedge clk);
    start = 1;
    header_len = LW'(8);
    payload_len = LW'(8);
    @(negedge clk);
    start = 0;
    in_valid = 1;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    in_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (wq.size() != 3 || fin_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: writes=%0d fin=%0d busy=%b want 3 0 0",
               wq.size(), fin_cnt, busy);
    end
    clr_mon();
    run_frame(2, 2, 0, -1);
    checks++;
    if (wq.size() != 4 || fin_cnt != 1) begin
      errors++;
      $display("FAIL reset_recover: writes=%0d fin=%0d want 4 1", wq.size(), fin_cnt);
    end
`ifdef INTER_RAM_WR_STATS_EN
    checks++;
    if (frames_done !== 16'd1 || frames_aborted !== 16'd0 || frames_rejected !== 16'd0) begin
      errors++;
      $display("FAIL stats: done=%0d ab=%0d rej=%0d want 1 0 0",
               frames_done, frames_aborted, frames_rejected);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int h = $urandom_range(0, 20);
      int p = $urandom_range(0, 20);
      clr_mon();
      run_frame(h, p, 1, -1);
      checks++;
      if (wq.size() != h + p || fin_cnt != 1 || rdy_bad != 0 || timeout != 0) begin
        errors++;
        $display("FAIL rand_frame(%0d,%0d): writes=%0d fin=%0d rdy_bad=%0d",
                 h, p, wq.size(), fin_cnt, rdy_bad);
      end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= wq.size() || wq[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_data[%0d]: want %h", i, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    clr_mon();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_short_frames();
    test_len_check();
    test_gaps();
    test_abort();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inter_ram_writer_ble.md
Name: inter_ram_writer_ble

Overview:
- Producer-side front end of the BLE PHY intermediate RAM.
- Accepts modulated TX samples over a valid/ready stream and frames them as a header segment followed by a payload segment.
- Drives the RAM write strobe and write data, then pulses tx_finished so the RX-side reader starts its header/gap/payload readout.
- Sits between the TX modulator output and the intermediate RAM write port.

Parameters:
- DATA, 12, sample width in bits.
- MEM, 8192, RAM depth in samples; a frame may not exceed this.
- LENW, 12, width of the header and payload length inputs.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame request; sampled only in IDLE.
- abort  in  1  cancel the current frame.
- header_len  in  LENW  header sample count; latched on accepted start.
- payload_len  in  LENW  payload sample count; latched on accepted start.
- in_valid  in  1  input sample valid.
- in_data  in  DATA  input sample.
- in_ready  out  1  writer accepts a sample this cycle.
- tx_valid_out  out  1  RAM write enable (registered).
- wr_data  out  DATA  RAM write data (registered).
- tx_finished  out  1  one-cycle end-of-frame pulse.
- busy  out  1  high in any state other than IDLE.
- len_error  out  1  one-cycle pulse when a start is rejected.
- aborted  out  1  one-cycle pulse when an abort is taken.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; counters 0; latched lengths 0.
- States and transitions:
  - IDLE -> HEADER on start when header_len > 0.
  - IDLE -> PAYLOAD on start when header_len == 0 and payload_len > 0.
  - IDLE -> DONE on start when both lengths are 0. tx_finished still pulses, so the reader sees an empty frame.
  - HEADER -> PAYLOAD on acceptance of the last header sample, or -> DONE if payload_len == 0.
  - PAYLOAD -> DONE on acceptance of the last payload sample.
  - DONE -> IDLE after one cycle, asserting tx_finished.
- Length check: if header_len + payload_len > MEM, computed at LENW+1 bits so the sum cannot wrap, start is rejected. len_error pulses and the state stays IDLE.
- in_ready = 1 in HEADER and PAYLOAD, 0 otherwise. It is a combinational decode of state only and never depends on in_valid.
- A transfer occurs when in_valid && in_ready. The next cycle, tx_valid_out = 1 and wr_data = in_data. Latency is exactly 1 cycle. With no transfer, tx_valid_out = 0 and wr_data holds its value.
- Counter: seg_cnt is LENW bits. It is cleared on entering HEADER or PAYLOAD and increments per transfer. The last sample of a segment is the transfer with seg_cnt == len-1.
- Timing of tx_finished: it is registered and asserted in the DONE cycle. That is one cycle after the final tx_valid_out pulse, so the final RAM write has already completed.
- start while busy: ignored, with no error.
- abort:
  - Has priority over everything else in the same cycle.
  - From HEADER or PAYLOAD: go to IDLE, pulse aborted, no tx_finished. A transfer accepted in the abort cycle is discarded, so no tx_valid_out follows.
  - In IDLE or DONE: ignored. DONE completes normally.
- Reset mid-frame: immediate return to IDLE. Pending tx_finished and tx_valid_out are suppressed.
- in_valid gaps of any length are tolerated. Frame length is counted in transfers, not cycles.

Optional Feature:
- Macro: INTER_RAM_WR_STATS_EN.
- With it defined, the block adds three outputs:
  - frames_done [15:0]: increments on each tx_finished.
  - frames_aborted [15:0]: increments on each aborted.
  - frames_rejected [15:0]: increments on each len_error.
  - All three saturate at 16'hFFFF and clear on reset.
- Without it, these ports and registers are absent. Core behaviour is identical in both builds.

Decomposition:
- Shared package ble_inter_ram_pkg holds:
  - the state encoding (IDLE=0, HEADER=1, PAYLOAD=2, DONE=3);
  - the default DATA, MEM and LENW values;
  - the reader wait constant of 17, used by benches.
- One sub-module, inter_ram_wr_seg_counter. It holds seg_cnt and the last-sample compare, with inputs clear, inc and len and output last. The FSM stays in the top level.

Test Plan:
1. header_len=4, payload_len=6, in_valid held high -> 10 tx_valid_out pulses with data matching input order; tx_finished exactly one cycle after the 10th; busy low on the following cycle.
2. header_len=0, payload_len=3 -> no HEADER state; 3 writes; tx_finished. Both lengths 0 -> tx_finished 2 cycles after start, with no writes.
3. header_len=4000, payload_len=4193 (sum 8193 > MEM) -> len_error pulse, busy stays 0, no writes. A sum of exactly 8192 is accepted.
4. in_valid toggled 1/0 pseudo-randomly, header 5, payload 5 -> exactly 10 writes; wr_data sequence equals the accepted in_data sequence.
5. abort asserted on the 3rd payload transfer -> aborted pulse, no tx_finished, tx_valid_out count = header + 2. A start 2 cycles later runs a clean frame.
6. reset asserted mid-header, then a new start with 2/2 -> exactly 4 writes and one tx_finished. With INTER_RAM_WR_STATS_EN, the counters read done=1, aborted=0, rejected=0.
